// File: rtl/perip_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : perip_arbiter
// Purpose  : Round-robin arbiter granting two masters access to one peripheral
//            slave port, with a per-transaction slave timeout.
// Revision : 1.0 - initial release
// ============================================================================
module perip_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    // master 0 (CPU execute stage)
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_mask,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    // master 1 (debug loader)
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_mask,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    // slave port
    output logic          s_req,
    output logic          s_we,
    output logic [DW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [3:0]    s_mask,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ack,
    // pipeline hold towards CPU control
    output logic          hold_o
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_BUSY    = 1'b1;
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic [7:0]    cnt_q,   cnt_d;
    logic          we_q,    we_d;
    logic [DW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    mask_q,  mask_d;

    logic          w_busy;
    logic          w_timeout;
    logic          w_done;
    logic          w_err;
    logic [DW-1:0] w_rdata;
    logic          w_grant_m1;

    // On a tie the master that did not win last time is granted.
    assign w_grant_m1 = m1_req & (~m0_req | ~last_q);

    assign w_busy    = (state_q == c_BUSY);
    assign w_timeout = (cnt_q == c_TO_LAST);
    // A slave ack in the timeout cycle still counts as a normal completion.
    assign w_done    = w_busy & (s_ack | w_timeout);
    assign w_err     = w_busy & ~s_ack & w_timeout;
    assign w_rdata   = (w_busy & s_ack) ? s_rdata : '0;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        case (state_q)
            c_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = c_BUSY;
                    owner_d = w_grant_m1;
                    last_d  = w_grant_m1;
                    cnt_d   = 8'd0;
                    we_d    = w_grant_m1 ? m1_we    : m0_we;
                    addr_d  = w_grant_m1 ? m1_addr  : m0_addr;
                    wdata_d = w_grant_m1 ? m1_wdata : m0_wdata;
                    mask_d  = w_grant_m1 ? m1_mask  : m0_mask;
                end
            end
            c_BUSY: begin
                if (w_done) begin
                    state_d = c_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        s_req    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_mask   = 4'd0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        if (w_busy) begin
            s_req   = 1'b1;
            s_we    = we_q;
            s_addr  = addr_q;
            s_wdata = wdata_q;
            s_mask  = mask_q;
            if (w_done) begin
                if (owner_q) begin
                    m1_ack   = 1'b1;
                    m1_err   = w_err;
                    m1_rdata = w_rdata;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = w_err;
                    m0_rdata = w_rdata;
                end
            end
        end
        // Reset gates the hold because m0_req is not a registered signal.
        hold_o = m0_req & ~m0_ack & ~rst;
    end

endmodule
`default_nettype wire

// File: tb/tb_perip_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_perip_arbiter
// Purpose  : Scoreboard bench for perip_arbiter (slave model + master drivers).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_perip_arbiter;

    localparam int TO = 8;
    localparam int DW = 32;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mreq = 2'b00;
    logic [1:0]    mwe  = 2'b00;
    logic [DW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic [3:0]    mmask  [2];
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_req, s_we, s_ack;
    logic [DW-1:0] s_addr, s_wdata, s_rdata;
    logic [3:0]    s_mask;
    logic          hold_o;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   sreq_cnt = 0;
    int   ack_delay = 0;
    logic [31:0] rd_xor = 32'h0;
    int   slv_cnt = 0;
    int   rep [2];
    logic [1:0] acked = 2'b00;
    exp_t sb [$];
    int   ack_cyc [$];
    int   ack_who [$];
    exp_t mon_e;
    int   mon_i;
    int   t0;
    int   base;

    perip_arbiter #(.TIMEOUT(TO), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(mreq[0]), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
        .m0_mask(mmask[0]), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(mreq[1]), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
        .m1_mask(mmask[1]), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_mask(s_mask), .s_rdata(s_rdata), .s_ack(s_ack), .hold_o(hold_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Drive a master request and record its expected completion.
    task automatic issue(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] mk);
        exp_t e;
        mreq[i] = 1'b1; mwe[i] = we; maddr[i] = a; mwdata[i] = wd; mmask[i] = mk;
        e.m = i; e.we = we; e.addr = a; e.wdata = wd; e.mask = mk;
        e.err   = (ack_delay < 0) || (ack_delay > TO - 1);
        e.rdata = e.err ? 32'h0 : (a ^ rd_xor);
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || mreq != 2'b00) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mreq = 2'b00;
        sb.delete();
        acked = 2'b00;
        rep[0] = 0; rep[1] = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Slave: acks ack_delay cycles into the transaction (negative = never).
    initial begin
        s_ack = 1'b0;
        s_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk); #1;
            if (rst || !s_req) begin
                slv_cnt = 0;
                s_ack   = 1'b0;
                s_rdata = 32'hDEAD_BEEF;
            end else begin
                s_ack   = (slv_cnt == ack_delay);
                s_rdata = s_addr ^ rd_xor;
                slv_cnt++;
            end
        end
    end

    // Masters: drop request after ack, or reissue while repeats remain.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acked[i]) begin
                    acked[i] = 1'b0;
                    if (rep[i] > 0) begin
                        rep[i]--;
                        issue(i, ~mwe[i], maddr[i] + 32'h10, mwdata[i] + 32'h1, mmask[i]);
                    end else begin
                        mreq[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: scoreboard compare on ack plus per-cycle output invariants.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_outs", 64'(s_req | hold_o | m0_ack | m1_ack | m0_err | m1_err |
                                    (|s_addr) | (|m0_rdata) | (|m1_rdata)), 64'd0);
            end else begin
                chk("hold_o", 64'(hold_o), 64'(mreq[0] & ~m0_ack));
                if (s_req) begin
                    sreq_cnt++;
                    if (sb.size() == 0) chk("s_req_spurious", 64'(s_req), 64'd0);
                    else begin
                        chk("s_we",    64'(s_we), 64'(sb[0].we));
                        chk("s_addr",  64'(s_addr), 64'(sb[0].addr));
                        chk("s_wdata", 64'(s_wdata), 64'(sb[0].wdata));
                        chk("s_mask",  64'(s_mask), 64'(sb[0].mask));
                    end
                end else begin
                    chk("s_idle_fields", 64'(s_we | (|s_addr) | (|s_wdata) | (|s_mask)), 64'd0);
                end
                if (m0_ack && m1_ack) begin
                    chk("dual_ack", 64'(m1_ack), 64'd0);
                end else if (m0_ack || m1_ack) begin
                    mon_i = m1_ack ? 1 : 0;
                    if (sb.size() == 0) chk("ack_spurious", 64'(mon_i + 1), 64'd0);
                    else begin
                        mon_e = sb.pop_front();
                        chk("ack_owner", 64'(mon_i), 64'(mon_e.m));
                        chk("ack_err",   64'(mon_i ? m1_err : m0_err), 64'(mon_e.err));
                        chk("ack_rdata", 64'(mon_i ? m1_rdata : m0_rdata), 64'(mon_e.rdata));
                        chk("nonowner_zero", 64'(mon_i ? (m0_err | (|m0_rdata))
                                                       : (m1_err | (|m1_rdata))), 64'd0);
                        ack_cyc.push_back(cyc);
                        ack_who.push_back(mon_i);
                        acked[mon_i] = 1'b1;
                    end
                end else begin
                    chk("no_ack_outs", 64'(m0_err | m1_err | (|m0_rdata) | (|m1_rdata)), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            maddr[i] = '0; mwdata[i] = '0; mmask[i] = 4'h0; rep[i] = 0;
        end
        // Reset with m0 requesting: hold_o must stay low.
        mreq = 2'b01;
        repeat (2) @(negedge clk);
        chk("rst_hold", 64'(hold_o), 64'd0);
        do_reset();

        // Single read with slave ack 3 cycles after s_req.
        ack_delay = 3;
        rd_xor = 32'h1000 ^ 32'hCAFE_0001;
        ack_cyc.delete(); ack_who.delete();
        t0 = cyc;
        issue(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        @(negedge clk); chk("read_sreq_pre", 64'(s_req), 64'd0);
        @(negedge clk); chk("read_sreq_on", 64'(s_req), 64'd1);
        wait_drain("read_drain", 100);
        chk("read_acks", 64'(ack_cyc.size()), 64'd1);
        if (ack_cyc.size() > 0) chk("read_latency", 64'(ack_cyc[0] - t0), 64'd5);

        // Both masters request continuously, immediate slave ack.
        do_reset();
        ack_delay = 0;
        rd_xor = 32'h1234_5678;
        ack_cyc.delete(); ack_who.delete();
        rep[0] = 3; rep[1] = 3;
        t0 = cyc;
        issue(0, 1'b0, 32'h0100, 32'hA000_0000, 4'hF);
        issue(1, 1'b1, 32'h0200, 32'hB000_0000, 4'h5);
        wait_drain("rr_drain", 200);
        chk("rr_count", 64'(ack_who.size()), 64'd8);
        if (ack_cyc.size() > 0) chk("rr_first_latency", 64'(ack_cyc[0] - t0), 64'd2);
        for (int j = 0; j < ack_who.size(); j++) begin
            chk("rr_order", 64'(ack_who[j]), 64'(j % 2));
            if (j > 0) chk("rr_spacing", 64'(ack_cyc[j] - ack_cyc[j-1]), 64'd2);
        end

        // Write that the slave never acknowledges: timeout error.
        ack_delay = -1;
        rd_xor = 32'h0F0F_0F0F;
        sreq_cnt = 0;
        issue(1, 1'b1, 32'h2004, 32'h55AA_55AA, 4'b0011);
        wait_drain("timeout_drain", 100);
        chk("timeout_sreq_cycles", 64'(sreq_cnt), 64'(TO));
        @(negedge clk); chk("timeout_idle", 64'(s_req), 64'd0);

        // Slave ack lands exactly on the timeout cycle: normal completion.
        ack_delay = TO - 1;
        rd_xor = 32'h3C3C_0000;
        sreq_cnt = 0;
        issue(0, 1'b0, 32'h3000, 32'h0, 4'hC);
        wait_drain("edge_drain", 100);
        chk("edge_sreq_cycles", 64'(sreq_cnt), 64'(TO));

        // Reset while m0 owns a transaction.
        ack_delay = -1;
        issue(0, 1'b0, 32'h6000, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        chk("rstmid_busy", 64'(s_req), 64'd1);
        base = ack_who.size();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rstmid_sreq_async", 64'(s_req), 64'd0);
        chk("rstmid_no_ack", 64'(m0_ack), 64'd0);
        mreq = 2'b00;
        sb.delete();
        acked = 2'b00;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rstmid_discarded", 64'(ack_who.size()), 64'(base));
        ack_delay = 0;
        rd_xor = 32'h0000_FFFF;
        issue(0, 1'b0, 32'h7000, 32'h0, 4'hF);
        issue(1, 1'b0, 32'h7100, 32'h0, 4'hF);
        wait_drain("rstmid_drain", 100);
        chk("rstmid_acks", 64'(ack_who.size() - base), 64'd2);
        if (ack_who.size() >= base + 2) begin
            chk("rstmid_first_m0", 64'(ack_who[base]), 64'd0);
            chk("rstmid_then_m1", 64'(ack_who[base+1]), 64'd1);
        end

        // m1 arrives while m0 busy; m0 drops its request mid-transaction.
        ack_delay = 4;
        rd_xor = 32'h5A5A_5A5A;
        base = ack_who.size();
        issue(0, 1'b0, 32'h4000, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        issue(1, 1'b1, 32'h5000, 32'h1111_2222, 4'b1001);
        mreq[0] = 1'b0;
        wait_drain("drop_drain", 100);
        chk("drop_acks", 64'(ack_who.size() - base), 64'd2);
        if (ack_who.size() >= base + 2) begin
            chk("drop_m0_acked", 64'(ack_who[base]), 64'd0);
            chk("drop_m1_next", 64'(ack_who[base+1]), 64'd1);
            chk("drop_gap", 64'(ack_cyc[base+1] - ack_cyc[base]), 64'd6);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perip_arbiter.md
PERIP_ARBITER -- requirements
Module: perip_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: BUSY cycles without s_ack before an error completion (range 2..255).
REQ-002 SHALL have parameter DW, default 32: address and data width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 m0_req / m1_req  in  1  master 0 (CPU ex stage) / master 1 (debug loader) request; held stable until matching ack.
REQ-006 m0_we / m1_we  in  1  write strobe (1 = write, 0 = read).
REQ-007 m0_addr, m0_wdata / m1_addr, m1_wdata  in  DW each  address, write data.
REQ-008 m0_mask / m1_mask  in  4  byte-enable mask.
REQ-009 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-010 m0_err / m1_err  out  1  timeout flag, valid only with ack.
REQ-011 m0_rdata / m1_rdata  out  DW  read data, valid only with ack.
REQ-012 s_req, s_we  out  1  slave request, write strobe.
REQ-013 s_addr, s_wdata  out  DW  slave address, write data.
REQ-014 s_mask  out  4  slave byte mask.
REQ-015 s_rdata  in  DW  slave read data.
REQ-016 s_ack  in  1  slave completion, sampled only while s_req=1.
REQ-017 hold_o  out  1  pipeline hold to CPU ctrl = m0_req & ~m0_ack.

Function
REQ-018 SHALL implement FSM states IDLE and BUSY, plus a 1-bit owner register, a 1-bit last-grant register and an 8-bit timeout counter.
REQ-019 IDLE: no request -> stay; exactly one requester -> grant it; both -> grant master not equal to last (round-robin).
REQ-020 On grant SHALL latch the owner's we/addr/wdata/mask, set owner and last, clear the counter, go to BUSY next edge.
REQ-021 BUSY: s_req=1 and s_we/s_addr/s_wdata/s_mask driven from latched fields only; IDLE: s_req=0 and s_* fields 0.
REQ-022 BUSY with s_ack=1: SHALL assert owner's ack combinationally the same cycle, pass s_rdata to owner's rdata, err=0, return to IDLE next edge.
REQ-023 BUSY without s_ack: counter increments; when counter = TIMEOUT-1 SHALL assert owner's ack and err for that cycle, rdata = 0, return to IDLE.
REQ-024 s_ack and timeout in the same cycle: normal completion wins (err=0).
REQ-025 Non-owner's ack, err and rdata SHALL be 0 at all times; rdata of both masters SHALL be 0 outside an ack cycle.
REQ-026 Latency: request sampled in IDLE at edge N -> s_req high from N; minimum request-to-ack 2 cycles; one IDLE bubble between transactions.
REQ-027 Owner dropping its req during BUSY SHALL NOT abort; the transaction completes and the ack is still pulsed.
REQ-028 Requests arriving during BUSY are not sampled until IDLE; no requester starves (at most one foreign transaction between grants when both request).
REQ-029 Writes and reads are treated identically by the FSM; mask passes unmodified.

Reset
REQ-030 rst high SHALL immediately force state IDLE, owner 0, last 1 (master 0 wins the first tie), counter 0, all outputs 0 including s_req and hold_o.
REQ-031 Reset mid-BUSY SHALL drop s_req asynchronously; the pending transaction is discarded with no ack.
REQ-032 After rst deasserts, the first arbitration occurs on the first rising edge.

Verification
REQ-033 m0 read addr 0x1000, slave acks 3 cycles after s_req with 0xCAFE0001 -> s_addr=0x1000, s_we=0, one m0_ack with m0_rdata=0xCAFE0001, m0_err=0, hold_o high until the ack cycle.
REQ-034 m0 and m1 both hold requests continuously, slave acks immediately -> grants alternate m0,m1,m0,m1 after reset; each ack 2 cycles apart.
REQ-035 m1 write addr 0x2004, wdata 0x55AA55AA, mask 0b0011, slave never acks -> s_req high exactly TIMEOUT cycles, then m1_ack=1, m1_err=1, m1_rdata=0, FSM returns to IDLE.
REQ-036 s_ack asserted on the cycle counter = TIMEOUT-1 -> m0_ack=1, m0_err=0, rdata passes through.
REQ-037 rst pulsed while BUSY (m0 owner) -> s_req=0 immediately, no m0_ack, next tie after release grants m0.
REQ-038 m1 request arrives while m0 BUSY, m0 drops req mid-transaction -> m0 still acked; m1 granted on the following IDLE cycle.
